// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multicycle CPU: instruction fields, ALU commands,
// datapath select encodings and the control FSM state set.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BR   = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REGA   = 2'd3;

  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;

  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_R, ST_EXEC_I, ST_WB_I,
    ST_MEM_ADDR, ST_MEM_RD, ST_WB_MEM, ST_MEM_WR, ST_BRANCH,
    ST_JUMP, ST_JAL, ST_JR, ST_ILLEGAL
  } state_e;

  typedef enum logic [2:0] {
    CLS_R_ALU, CLS_JR, CLS_IMM, CLS_MEM, CLS_BRANCH, CLS_J, CLS_JAL, CLS_ILL
  } instr_class_e;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Instruction classifier: maps opcode/funct to a class, the execute-phase ALU
// command and an illegal bit.
module ctrl_decode
  import cpu_defs::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls,
  output logic [2:0]   alu_cmd,
  output logic         illegal
);

  always_comb begin
    cls     = CLS_ILL;
    alu_cmd = ALU_ADD;
    illegal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin cls = CLS_R_ALU; alu_cmd = ALU_ADD; illegal = 1'b0; end
          FN_SUB:  begin cls = CLS_R_ALU; alu_cmd = ALU_SUB; illegal = 1'b0; end
          FN_SLT:  begin cls = CLS_R_ALU; alu_cmd = ALU_SLT; illegal = 1'b0; end
          FN_JR:   begin cls = CLS_JR;    illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_ADDI: begin cls = CLS_IMM;    alu_cmd = ALU_ADD; illegal = 1'b0; end
      OP_XORI: begin cls = CLS_IMM;    alu_cmd = ALU_XOR; illegal = 1'b0; end
      OP_LW,
      OP_SW:   begin cls = CLS_MEM;    alu_cmd = ALU_ADD; illegal = 1'b0; end
      OP_BEQ,
      OP_BNE:  begin cls = CLS_BRANCH; alu_cmd = ALU_SUB; illegal = 1'b0; end
      OP_J:    begin cls = CLS_J;      illegal = 1'b0; end
      OP_JAL:  begin cls = CLS_JAL;    illegal = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, and counts retired instructions.
//
// state     | meaning
// FETCH     | read instruction at PC, PC+=4 when memory completes
// DECODE    | classify, precompute branch target into ALUOut
// EXEC_R/I  | R-type / immediate ALU op
// WB_R/I    | write ALU result to rd / rt
// MEM_ADDR  | effective address into ALUOut
// MEM_RD/WR | data memory access, held until mem_ready
// WB_MEM    | write MDR to rt
// BRANCH    | compare, conditionally load PC from ALUOut
// JUMP/JAL  | PC <= jump target (JAL also links r31)
// JR        | PC <= reg A
// ILLEGAL   | absorbing; only reset leaves
module multicycle_ctrl
  import cpu_defs::*;
#(
  parameter state_e RESET_STATE = ST_FETCH,
  parameter int     CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [2:0]       alu_cmd,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             imm_zext,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  instr_class_e       dec_cls;
  logic [2:0]         dec_alu_cmd;
  logic               dec_illegal;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (dec_cls),
    .alu_cmd (dec_alu_cmd),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_d = retired_q + CNT_W'(retire);
  assign retired   = retired_q;

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    alu_cmd   = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REG;
    imm_zext  = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_ALU;
    ir_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = DST_RT;
    wd_src    = WD_ALUOUT;
    illegal   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // Reset holds the FSM here; gating on rst_n drops the request at once.
        mem_req = rst_n;
        if (mem_ready && rst_n) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          alu_src_b = SRCB_FOUR;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_BR;
        if (dec_illegal) begin
          state_d = ST_ILLEGAL;
        end else begin
          case (dec_cls)
            CLS_R_ALU:  state_d = ST_EXEC_R;
            CLS_JR:     state_d = ST_JR;
            CLS_IMM:    state_d = ST_EXEC_I;
            CLS_MEM:    state_d = ST_MEM_ADDR;
            CLS_BRANCH: state_d = ST_BRANCH;
            CLS_J:      state_d = ST_JUMP;
            CLS_JAL:    state_d = ST_JAL;
            default:    state_d = ST_ILLEGAL;
          endcase
        end
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_cmd   = dec_alu_cmd;
        state_d   = ST_WB_R;
      end
      ST_WB_R: begin
        reg_we  = 1'b1;
        reg_dst = DST_RD;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_cmd   = dec_alu_cmd;
        imm_zext  = (opcode == OP_XORI);
        state_d   = ST_WB_I;
      end
      ST_WB_I: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = ST_WB_MEM;
      end
      ST_WB_MEM: begin
        reg_we  = 1'b1;
        wd_src  = WD_MDR;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_cmd   = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_we     = (opcode == OP_BNE) ? !alu_zero : alu_zero;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_we   = 1'b1;
        pc_src  = PC_JUMP;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JAL: begin
        pc_we   = 1'b1;
        pc_src  = PC_JUMP;
        reg_we  = 1'b1;
        reg_dst = DST_R31;
        wd_src  = WD_PC;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JR: begin
        pc_we   = 1'b1;
        pc_src  = PC_REGA;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_ILLEGAL: illegal = 1'b1;
      default:    state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level
// model; a 3-bit-counter instance shadows the main one to exercise wrap-around.
module tb_multicycle_ctrl;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic alu_zero = 1'b0, mem_ready = 1'b0;

  logic [2:0] a_alu_cmd, s_alu_cmd;
  logic a_src_a, s_src_a, a_zext, s_zext, a_pc_we, s_pc_we, a_ir_we, s_ir_we;
  logic a_mem_req, s_mem_req, a_mem_we, s_mem_we, a_iord, s_iord;
  logic a_reg_we, s_reg_we, a_illegal, s_illegal;
  logic [1:0] a_src_b, s_src_b, a_pc_src, s_pc_src, a_reg_dst, s_reg_dst, a_wd_src, s_wd_src;
  logic [31:0] a_retired;
  logic [2:0]  s_retired;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_cmd(a_alu_cmd), .alu_src_a(a_src_a), .alu_src_b(a_src_b), .imm_zext(a_zext),
    .pc_we(a_pc_we), .pc_src(a_pc_src), .ir_we(a_ir_we), .mem_req(a_mem_req),
    .mem_we(a_mem_we), .iord(a_iord), .reg_we(a_reg_we), .reg_dst(a_reg_dst),
    .wd_src(a_wd_src), .illegal(a_illegal), .retired(a_retired)
  );

  multicycle_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_cmd(s_alu_cmd), .alu_src_a(s_src_a), .alu_src_b(s_src_b), .imm_zext(s_zext),
    .pc_we(s_pc_we), .pc_src(s_pc_src), .ir_we(s_ir_we), .mem_req(s_mem_req),
    .mem_we(s_mem_we), .iord(s_iord), .reg_we(s_reg_we), .reg_dst(s_reg_dst),
    .wd_src(s_wd_src), .illegal(s_illegal), .retired(s_retired)
  );

  always #5 clk = ~clk;

  // Output vector: {cmd, src_a, src_b, zext, pc_we, pc_src, ir_we, mem_req, mem_we, iord, reg_we, reg_dst, wd_src, illegal}
  logic [19:0] a_vec, s_vec;
  assign a_vec = {a_alu_cmd, a_src_a, a_src_b, a_zext, a_pc_we, a_pc_src, a_ir_we, a_mem_req,
                  a_mem_we, a_iord, a_reg_we, a_reg_dst, a_wd_src, a_illegal};
  assign s_vec = {s_alu_cmd, s_src_a, s_src_b, s_zext, s_pc_we, s_pc_src, s_ir_we, s_mem_req,
                  s_mem_we, s_iord, s_reg_we, s_reg_dst, s_wd_src, s_illegal};

  localparam int P_FETCH = 0, P_DEC = 1, P_EXR = 2, P_WBR = 3, P_EXI = 4, P_WBI = 5,
                 P_ADDR = 6, P_RD = 7, P_WBM = 8, P_WR = 9, P_BR = 10, P_J = 11,
                 P_JAL = 12, P_JR = 13, P_ILL = 14;

  int errors = 0;
  int checks = 0;
  int ncyc;
  logic [31:0] cnt = 0;
  logic [19:0] exp_vec = '0;
  bit check_en = 1'b0;

  // Expected outputs for one cycle of an instruction, straight from the per-phase rules.
  function automatic logic [19:0] model(int ph, bit rdy, bit zero, logic [5:0] op, logic [5:0] fn);
    logic [2:0] cmd = 3'd0;
    logic sa = 0, zx = 0, pcwe = 0, irwe = 0, mreq = 0, mwe = 0, io = 0, rwe = 0, ill = 0;
    logic [1:0] sb = 0, pcs = 0, rd = 0, wd = 0;
    case (ph)
      P_FETCH: begin mreq = 1; if (rdy) begin irwe = 1; pcwe = 1; sb = 1; end end
      P_DEC:   sb = 3;
      P_EXR:   begin sa = 1; cmd = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0; end
      P_WBR:   begin rwe = 1; rd = 1; end
      P_EXI:   begin sa = 1; sb = 2; if (op == 6'h0E) begin cmd = 3'd2; zx = 1; end end
      P_WBI:   rwe = 1;
      P_ADDR:  begin sa = 1; sb = 2; end
      P_RD:    begin mreq = 1; io = 1; end
      P_WBM:   begin rwe = 1; wd = 1; end
      P_WR:    begin mreq = 1; mwe = 1; io = 1; end
      P_BR:    begin sa = 1; cmd = 3'd1; pcs = 1; pcwe = (op == 6'h05) ? !zero : zero; end
      P_J:     begin pcwe = 1; pcs = 2; end
      P_JAL:   begin pcwe = 1; pcs = 2; rwe = 1; rd = 2; wd = 2; end
      P_JR:    begin pcwe = 1; pcs = 3; end
      P_ILL:   ill = 1;
      default: ;
    endcase
    return {cmd, sa, sb, zx, pcwe, pcs, irwe, mreq, mwe, io, rwe, rd, wd, ill};
  endfunction

  function automatic bit retires(int ph, bit rdy);
    return (ph == P_WBR || ph == P_WBI || ph == P_WBM || ph == P_BR || ph == P_J ||
            ph == P_JAL || ph == P_JR || (ph == P_WR && rdy));
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("outputs", 64'(a_vec), 64'(exp_vec));
      check("outputs_w3", 64'(s_vec), 64'(exp_vec));
      check("retired", 64'(a_retired), 64'(cnt));
      check("retired_w3", 64'(s_retired), 64'(cnt[2:0]));
    end
  end

  // Called at posedge+1: drive inputs for this cycle, publish expectation, advance.
  task automatic step(int ph, bit rdy, bit zero);
    mem_ready = rdy;
    alu_zero  = zero;
    exp_vec   = model(ph, rdy, zero, opcode, funct);
    check_en  = 1'b1;
    ncyc++;
    @(posedge clk);
    #1;
    if (retires(ph, rdy)) cnt++;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit zero, int fw, int mw);
    opcode = op;
    funct  = fn;
    ncyc   = 0;
    repeat (fw) step(P_FETCH, 0, rb());
    step(P_FETCH, 1, rb());
    step(P_DEC, rb(), rb());
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
      step(P_EXR, rb(), rb()); step(P_WBR, rb(), rb());
    end else if (op == 6'h00 && fn == 6'h08) begin
      step(P_JR, rb(), rb());
    end else if (op == 6'h08 || op == 6'h0E) begin
      step(P_EXI, rb(), rb()); step(P_WBI, rb(), rb());
    end else if (op == 6'h23) begin
      step(P_ADDR, rb(), rb());
      repeat (mw) step(P_RD, 0, rb());
      step(P_RD, 1, rb());
      step(P_WBM, rb(), rb());
    end else if (op == 6'h2B) begin
      step(P_ADDR, rb(), rb());
      repeat (mw) step(P_WR, 0, rb());
      step(P_WR, 1, rb());
    end else if (op == 6'h04 || op == 6'h05) begin
      step(P_BR, rb(), zero);
    end else if (op == 6'h02) begin
      step(P_J, rb(), rb());
    end else if (op == 6'h03) begin
      step(P_JAL, rb(), rb());
    end else begin
      repeat (100) step(P_ILL, rb(), rb());
    end
  endtask

  logic [5:0] tbl_op [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0E, 6'h23, 6'h2B,
                              6'h04, 6'h05, 6'h02, 6'h03, 6'h23};
  logic [5:0] tbl_fn [13] = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h11, 6'h3F, 6'h00, 6'h15,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h2A};

  initial begin
    #2;
    check("rst_outputs", 64'(a_vec), 64'h0);
    check("rst_retired", 64'(a_retired), 64'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr(6'h00, 6'h20, 0, 0, 0);
    check("add_cycles", 64'(ncyc), 64'd4);
    check("add_retired", 64'(a_retired), 64'd1);

    run_instr(6'h23, 6'h00, 0, 3, 3);
    check("lw_cycles", 64'(ncyc), 64'd11);
    check("lw_retired", 64'(a_retired), 64'd2);

    run_instr(6'h04, 6'h00, 1, 0, 0);
    run_instr(6'h05, 6'h00, 1, 1, 0);
    check("bne_retired", 64'(a_retired), 64'd4);

    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 12);
      run_instr(tbl_op[k], tbl_fn[k], rb(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while waiting in the data read.
    opcode = 6'h23; funct = 6'h00;
    step(P_FETCH, 1, 0); step(P_DEC, 0, 0); step(P_ADDR, 0, 0); step(P_RD, 0, 0);
    mem_ready = 1'b0;
    check_en  = 1'b0;
    check("rd_mem_req_before_rst", 64'(a_mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 64'(a_mem_req), 64'd0);
    check("rst_mid_retired", 64'(a_retired), 64'd0);
    check("rst_mid_retired_w3", 64'(s_retired), 64'd0);
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (8) run_instr(6'h02, 6'h00, 0, 0, 0);
    check("wrap_w3", 64'(s_retired), 64'd0);
    check("eight_retired", 64'(a_retired), 64'd8);

    run_instr(6'h03, 6'h00, 0, 0, 0);
    check("jal_cycles", 64'(ncyc), 64'd3);
    run_instr(6'h3F, 6'h00, 0, 0, 0);
    check("illegal_flag", 64'(a_illegal), 64'd1);
    check("illegal_retired_frozen", 64'(a_retired), 64'd9);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
